// File: rtl/operand_fetch.sv
// operand_fetch: issue stage between decode and the register file read ports.
// It latches one instruction's source pair, reads the register file for one
// cycle and captures the read data. Writeback traffic that the read-before-write
// register file cannot show is forwarded. The operands and tag then go to
// execute over a valid/ready handshake, and they keep tracking writes while held.
module operand_fetch #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int DATA_W   = 64,
    parameter int TAG_W    = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_rs0,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [1:0]        in_use,
    input  logic [TAG_W-1:0]  in_tag,
    output logic [1:0]        rf_read_en,
    output logic [ADDR_W-1:0] rf_raddr_0,
    output logic [ADDR_W-1:0] rf_raddr_1,
    input  logic [DATA_W-1:0] rf_rdata_0,
    input  logic [DATA_W-1:0] rf_rdata_1,
    input  logic              wb_en,
    input  logic [ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op0,
    output logic [DATA_W-1:0] out_op1,
    output logic [TAG_W-1:0]  out_tag
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CAPT = 2'd2,
        ST_HOLD = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Latched instruction. The read addresses double as the latched source registers.
    logic [ADDR_W-1:0] raddr0_q, raddr0_d;
    logic [ADDR_W-1:0] raddr1_q, raddr1_d;
    logic [1:0]        use_q,    use_d;
    logic [TAG_W-1:0]  tag_q,    tag_d;
    logic [1:0]        rd_en_q,  rd_en_d;

    // Writes seen during READ, which the register file will not return.
    logic              fwd0_q,      fwd0_d;
    logic              fwd1_q,      fwd1_d;
    logic [DATA_W-1:0] fwd_data0_q, fwd_data0_d;
    logic [DATA_W-1:0] fwd_data1_q, fwd_data1_d;

    // Presented operands.
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] op0_q,       op0_d;
    logic [DATA_W-1:0] op1_q,       op1_d;
    logic [TAG_W-1:0]  out_tag_q,   out_tag_d;

    logic in_ready_s;
    logic accept_s;
    logic wb_hit0_s;
    logic wb_hit1_s;

    // Capture-cycle operand choice: a write in this cycle beats an earlier
    // forwarded write, which beats the register file data.
    function automatic logic [DATA_W-1:0] capt_sel(
        input logic              used,
        input logic              hit,
        input logic [DATA_W-1:0] wdata,
        input logic              fwd,
        input logic [DATA_W-1:0] fdata,
        input logic [DATA_W-1:0] rdata
    );
        logic [DATA_W-1:0] res;
        if (!used) begin
            res = '0;
        end else if (hit) begin
            res = wdata;
        end else if (fwd) begin
            res = fdata;
        end else begin
            res = rdata;
        end
        return res;
    endfunction

    assign in_ready_s = (state_q == ST_IDLE) | ((state_q == ST_HOLD) & out_ready);
    assign accept_s   = in_valid & in_ready_s;
    assign wb_hit0_s  = wb_en & (wb_addr == raddr0_q) & use_q[0];
    assign wb_hit1_s  = wb_en & (wb_addr == raddr1_q) & use_q[1];

    // Next-state logic for the issue FSM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    state_d = ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: state_d = ST_CAPT;
            ST_CAPT: state_d = ST_HOLD;
            ST_HOLD: begin
                if (out_ready) begin
                    if (in_valid) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_HOLD;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Next-state logic for the latched instruction, forwarding and output registers.
    always_comb begin
        raddr0_d    = raddr0_q;
        raddr1_d    = raddr1_q;
        use_d       = use_q;
        tag_d       = tag_q;
        rd_en_d     = 2'b00;
        fwd0_d      = fwd0_q;
        fwd1_d      = fwd1_q;
        fwd_data0_d = fwd_data0_q;
        fwd_data1_d = fwd_data1_q;
        op0_d       = op0_q;
        op1_d       = op1_q;
        out_tag_d   = out_tag_q;

        // The accept edge enters READ, so the read enables are live exactly during READ.
        if (accept_s) begin
            raddr0_d = in_rs0;
            raddr1_d = in_rs1;
            use_d    = in_use;
            tag_d    = in_tag;
            rd_en_d  = in_use;
            fwd0_d   = 1'b0;
            fwd1_d   = 1'b0;
        end else begin
            rd_en_d  = 2'b00;
        end

        case (state_q)
            ST_READ: begin
                if (wb_hit0_s) begin
                    fwd0_d      = 1'b1;
                    fwd_data0_d = wb_data;
                end else begin
                    fwd0_d      = fwd0_q;
                end
                if (wb_hit1_s) begin
                    fwd1_d      = 1'b1;
                    fwd_data1_d = wb_data;
                end else begin
                    fwd1_d      = fwd1_q;
                end
            end
            ST_CAPT: begin
                op0_d     = capt_sel(use_q[0], wb_hit0_s, wb_data, fwd0_q, fwd_data0_q, rf_rdata_0);
                op1_d     = capt_sel(use_q[1], wb_hit1_s, wb_data, fwd1_q, fwd_data1_q, rf_rdata_1);
                out_tag_d = tag_q;
            end
            ST_HOLD: begin
                // Track writes while held. A write on the handoff edge belongs to nobody.
                if (!out_ready && wb_hit0_s) begin
                    op0_d = wb_data;
                end else begin
                    op0_d = op0_q;
                end
                if (!out_ready && wb_hit1_s) begin
                    op1_d = wb_data;
                end else begin
                    op1_d = op1_q;
                end
            end
            default: begin
                op0_d = op0_q;
                op1_d = op1_q;
            end
        endcase

        out_valid_d = (state_d == ST_HOLD);
    end

    // State and datapath registers; reset discards any in-flight instruction.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            raddr0_q    <= '0;
            raddr1_q    <= '0;
            use_q       <= 2'b00;
            tag_q       <= '0;
            rd_en_q     <= 2'b00;
            fwd0_q      <= 1'b0;
            fwd1_q      <= 1'b0;
            fwd_data0_q <= '0;
            fwd_data1_q <= '0;
            out_valid_q <= 1'b0;
            op0_q       <= '0;
            op1_q       <= '0;
            out_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            raddr0_q    <= raddr0_d;
            raddr1_q    <= raddr1_d;
            use_q       <= use_d;
            tag_q       <= tag_d;
            rd_en_q     <= rd_en_d;
            fwd0_q      <= fwd0_d;
            fwd1_q      <= fwd1_d;
            fwd_data0_q <= fwd_data0_d;
            fwd_data1_q <= fwd_data1_d;
            out_valid_q <= out_valid_d;
            op0_q       <= op0_d;
            op1_q       <= op1_d;
            out_tag_q   <= out_tag_d;
        end
    end

    assign in_ready   = in_ready_s;
    assign rf_read_en = rd_en_q;
    assign rf_raddr_0 = raddr0_q;
    assign rf_raddr_1 = raddr1_q;
    assign out_valid  = out_valid_q;
    assign out_op0    = op0_q;
    assign out_op1    = op1_q;
    assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_operand_fetch.sv
// Bench for operand_fetch: a register file model feeds the read ports, and a
// transaction-level model predicts what execute must see. The bench expects
// each accepted instruction to present, from accept+3 cycles until handoff, the
// architectural register values as of that cycle.
module tb_operand_fetch;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs0, in_rs1;
    logic [1:0]  in_use;
    logic [7:0]  in_tag;
    logic [1:0]  rf_read_en;
    logic [4:0]  rf_raddr_0, rf_raddr_1;
    logic [63:0] rf_rdata_0, rf_rdata_1;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [63:0] wb_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_op0, out_op1;
    logic [7:0]  out_tag;

    operand_fetch dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_rs0     (in_rs0),
        .in_rs1     (in_rs1),
        .in_use     (in_use),
        .in_tag     (in_tag),
        .rf_read_en (rf_read_en),
        .rf_raddr_0 (rf_raddr_0),
        .rf_raddr_1 (rf_raddr_1),
        .rf_rdata_0 (rf_rdata_0),
        .rf_rdata_1 (rf_rdata_1),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_op0    (out_op0),
        .out_op1    (out_op1),
        .out_tag    (out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] rs0;
        logic [4:0] rs1;
        logic [1:0] usem;
        logic [7:0] tag;
        int         acc;
    } ent_t;

    ent_t        q[$];
    logic [63:0] mem [32];
    logic [7:0]  hand_tag[$];
    int          hand_cyc[$];
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Transaction model: handoffs, accepts and architectural register writes.
    always @(posedge clk) begin
        if (reset_n) begin
            if (q.size() > 0 && out_valid && out_ready) begin
                hand_tag.push_back(out_tag);
                hand_cyc.push_back(cyc);
                void'(q.pop_front());
            end
            if (in_valid && in_ready) begin
                q.push_back('{rs0: in_rs0, rs1: in_rs1, usem: in_use, tag: in_tag, acc: cyc});
            end
        end
        if (wb_en) mem[wb_addr] <= wb_data;
        cyc++;
    end

    // Register file model: read-before-write, data one cycle after the enable.
    logic [1:0]  rf_re_s;
    logic [63:0] rf_v0_s, rf_v1_s;
    always @(posedge clk) begin
        rf_re_s = rf_read_en;
        rf_v0_s = mem[rf_raddr_0];
        rf_v1_s = mem[rf_raddr_1];
        #1;
        rf_rdata_0 = rf_re_s[0] ? rf_v0_s : 64'hBAD0_BAD0_BAD0_BAD0;
        rf_rdata_1 = rf_re_s[1] ? rf_v1_s : 64'hBAD1_BAD1_BAD1_BAD1;
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        logic       exp_valid;
        logic [1:0] exp_ren;
        logic       exp_rdy;
        if (!reset_n) begin
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_read_en", {62'd0, rf_read_en}, 64'd0);
        end else begin
            exp_valid = (q.size() > 0) && (cyc >= q[0].acc + 3);
            exp_ren   = ((q.size() > 0) && (cyc == q[0].acc + 1)) ? q[0].usem : 2'b00;
            exp_rdy   = (q.size() == 0) || (exp_valid && out_ready);
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_valid});
            chk("rf_read_en", {62'd0, rf_read_en}, {62'd0, exp_ren});
            chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
            if (exp_ren != 2'b00) begin
                chk("rf_raddr_0", {59'd0, rf_raddr_0}, {59'd0, q[0].rs0});
                chk("rf_raddr_1", {59'd0, rf_raddr_1}, {59'd0, q[0].rs1});
            end
            if (exp_valid) begin
                chk("out_op0", out_op0, q[0].usem[0] ? mem[q[0].rs0] : 64'd0);
                chk("out_op1", out_op1, q[0].usem[1] ? mem[q[0].rs1] : 64'd0);
                chk("out_tag", {56'd0, out_tag}, {56'd0, q[0].tag});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer one instruction from IDLE; returns one step later, in READ.
    task automatic issue(input logic [4:0] rs0, input logic [4:0] rs1,
                         input logic [1:0] u, input logic [7:0] tag);
        in_valid = 1'b1;
        in_rs0   = rs0;
        in_rs1   = rs1;
        in_use   = u;
        in_tag   = tag;
        step();
        in_valid = 1'b0;
    endtask

    task automatic handoff();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < 32; i++) mem[i] = 64'h1000 + 64'(i);
        mem[3] = 64'hA;
        mem[7] = 64'hB;
        mem[9] = 64'h9;
        reset_n = 1'b0; in_valid = 1'b0; in_rs0 = 5'd0; in_rs1 = 5'd0; in_use = 2'b00;
        in_tag = 8'd0; wb_en = 1'b0; wb_addr = 5'd0; wb_data = 64'd0; out_ready = 1'b0;
        rf_rdata_0 = 64'd0; rf_rdata_1 = 64'd0;
        step(); step();
        chk("reset_in_ready", {63'd0, in_ready}, 64'd1);
        chk("reset_raddr_0", {59'd0, rf_raddr_0}, 64'd0);
        chk("reset_op0", out_op0, 64'd0);
        chk("reset_tag", {56'd0, out_tag}, 64'd0);
        reset_n = 1'b1;
        step();

        // 1: basic fetch, three-cycle latency, one-cycle read enable
        issue(5'd3, 5'd7, 2'b11, 8'h11);
        chk("t1_read_en", {62'd0, rf_read_en}, 64'h3);
        step();
        chk("t1_read_en_off", {62'd0, rf_read_en}, 64'h0);
        chk("t1_not_valid_capt", {63'd0, out_valid}, 64'd0);
        step();
        chk("t1_valid", {63'd0, out_valid}, 64'd1);
        chk("t1_op0", out_op0, 64'hA);
        chk("t1_op1", out_op1, 64'hB);
        handoff();
        chk("t1_valid_drop", {63'd0, out_valid}, 64'd0);

        // 2: unused operand 1 is neither read nor presented
        issue(5'd3, 5'd7, 2'b01, 8'h22);
        chk("t2_read_en", {62'd0, rf_read_en}, 64'h1);
        step(); step();
        chk("t2_op0", out_op0, 64'hA);
        chk("t2_op1_zero", out_op1, 64'h0);
        handoff();

        // 3: write in READ then CAPT; later write to an unrelated register
        issue(5'd3, 5'd7, 2'b11, 8'h33);
        wb_en = 1'b1; wb_addr = 5'd3; wb_data = 64'h55;
        step();
        wb_data = 64'h66;
        step();
        wb_en = 1'b0;
        chk("t3_op0_fwd", out_op0, 64'h66);
        wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h99;
        step();
        wb_en = 1'b0;
        chk("t3_op0_r9", out_op0, 64'h66);
        chk("t3_op1_r9", out_op1, 64'hB);
        handoff();

        // 4: write tracking while held
        issue(5'd3, 5'd7, 2'b11, 8'h44);
        step(); step();
        step();
        wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'h77;
        step();
        wb_en = 1'b0;
        chk("t4_op1_track", out_op1, 64'h77);
        chk("t4_tag", {56'd0, out_tag}, 64'h44);
        step(); step();
        chk("t4_op1_hold", out_op1, 64'h77);
        handoff();

        // 5: back-to-back stream, tags 1..3
        hand_tag.delete();
        hand_cyc.delete();
        out_ready = 1'b1;
        in_rs0 = 5'd3; in_rs1 = 5'd7; in_use = 2'b11;
        for (int t = 1; t <= 3; t++) begin
            in_valid = 1'b1;
            in_tag = 8'(t);
            k = 0;
            while (!in_ready && k < 10) begin
                step();
                k++;
            end
            if (t > 1) chk("t5_wait", 64'(k), 64'd2);
            step();
        end
        in_valid = 1'b0;
        k = 0;
        while (hand_tag.size() < 3 && k < 20) begin
            step();
            k++;
        end
        out_ready = 1'b0;
        chk("t5_count", 64'(hand_tag.size()), 64'd3);
        for (int i = 0; i < hand_tag.size(); i++) begin
            chk("t5_tag_order", {56'd0, hand_tag[i]}, 64'(i + 1));
            if (i > 0) chk("t5_spacing", 64'(hand_cyc[i] - hand_cyc[i-1]), 64'd3);
        end
        step();

        // 6: asynchronous reset during CAPT
        issue(5'd3, 5'd7, 2'b11, 8'h66);
        step();
        #2;
        reset_n = 1'b0;
        q.delete();
        #1;
        chk("t6_valid", {63'd0, out_valid}, 64'd0);
        chk("t6_read_en", {62'd0, rf_read_en}, 64'd0);
        chk("t6_op0", out_op0, 64'd0);
        chk("t6_op1", out_op1, 64'd0);
        chk("t6_tag", {56'd0, out_tag}, 64'd0);
        step(); step();
        reset_n = 1'b1;
        chk("t6_in_ready", {63'd0, in_ready}, 64'd1);
        step();
        chk("t6_idle_valid", {63'd0, out_valid}, 64'd0);

        // Post-reset transaction, only operand 1 used
        issue(5'd9, 5'd3, 2'b10, 8'h77);
        step(); step();
        chk("t6_post_op0", out_op0, 64'd0);
        chk("t6_post_op1", out_op1, 64'h66);
        chk("t6_post_tag", {56'd0, out_tag}, 64'h77);
        handoff();
        step(); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
